// File: rtl/elevator_call_latch.sv
// Request-capture stage: synchronises and debounces seven push-buttons and holds
// each confirmed press as a sticky request until the car opens at that floor.
module elevator_call_latch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] raw_btn,
    input  logic       floor_one,
    input  logic       floor_two,
    input  logic       floor_three,
    input  logic       elevator_open,
    output logic [6:0] req,
    output logic       any_req
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [6:0]       s1;
    logic [6:0]       s2;
    logic [6:0]       db;
    logic [CNT_W-1:0] cnt      [7];
    logic [CNT_W-1:0] cnt_next [7];
    logic [6:0]       db_next;
    logic [6:0]       set;
    logic [6:0]       clr;
    logic [6:0]       req_next;
    logic             svc_1;
    logic             svc_2;
    logic             svc_3;

    always_comb begin
        db_next = db;
        set     = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            cnt_next[i] = cnt[i];
            if (s2[i] == db[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                db_next[i]  = s2[i];
                cnt_next[i] = '0;
                set[i]      = s2[i];
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Malformed multi-floor indications simply clear every indicated floor.
    assign svc_1    = elevator_open & floor_one;
    assign svc_2    = elevator_open & floor_two;
    assign svc_3    = elevator_open & floor_three;
    assign clr      = {svc_3, svc_2, svc_1, svc_3, svc_2, svc_2, svc_1};
    assign req_next = (req | set) & ~clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            db      <= '0;
            req     <= '0;
            any_req <= 1'b0;
            for (int unsigned i = 0; i < 7; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= raw_btn;
            s2      <= s1;
            db      <= db_next;
            req     <= req_next;
            any_req <= |req_next;
            for (int unsigned i = 0; i < 7; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_elevator_call_latch.sv
// Bench for elevator_call_latch: default instance plus a DEBOUNCE_CYCLES=1 instance,
// both scored every cycle against a run-length reference model.
module tb_elevator_call_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] raw_btn;
    logic       floor_one, floor_two, floor_three, elevator_open;
    logic [6:0] req_a, req_b;
    logic       any_a, any_b;

    elevator_call_latch #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .raw_btn(raw_btn),
        .floor_one(floor_one), .floor_two(floor_two), .floor_three(floor_three),
        .elevator_open(elevator_open), .req(req_a), .any_req(any_a)
    );

    elevator_call_latch #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut_b (
        .clk(clk), .rst(rst), .raw_btn(raw_btn),
        .floor_one(floor_one), .floor_two(floor_two), .floor_three(floor_three),
        .elevator_open(elevator_open), .req(req_b), .any_req(any_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit done  = 1'b0;

    logic [15:0] sb_q [$];

    // Reference model: a button level is accepted once the synchronised value has
    // disagreed with the accepted level for DC consecutive edges.
    int unsigned dc [2] = '{4, 1};
    int unsigned run [2][7];
    logic [6:0]  m_db  [2];
    logic [6:0]  m_req [2];
    logic [6:0]  prev1, prev2;

    task automatic model_edge(input logic [6:0] raw, input logic f1, input logic f2,
                              input logic f3, input logic op, input logic r);
        logic [6:0] clr;
        logic [6:0] set;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                m_db[k] = '0;
                m_req[k] = '0;
                for (int b = 0; b < 7; b++) run[k][b] = 0;
            end
            prev1 = '0;
            prev2 = '0;
        end else begin
            clr = '0;
            if (op && f1) clr = clr | 7'b0010001;
            if (op && f2) clr = clr | 7'b0100110;
            if (op && f3) clr = clr | 7'b1001000;
            for (int k = 0; k < 2; k++) begin
                set = '0;
                for (int b = 0; b < 7; b++) begin
                    if (prev2[b] != m_db[k][b]) begin
                        run[k][b]++;
                        if (run[k][b] >= dc[k]) begin
                            m_db[k][b] = prev2[b];
                            run[k][b] = 0;
                            if (prev2[b]) set[b] = 1'b1;
                        end
                    end else begin
                        run[k][b] = 0;
                    end
                end
                m_req[k] = (m_req[k] | set) & ~clr;
            end
            prev2 = prev1;
            prev1 = raw;
        end
        sb_q.push_back({|m_req[1], m_req[1], |m_req[0], m_req[0]});
    endtask

    // Drive one cycle's inputs away from the active edge and log the expectation.
    task automatic step(input logic [6:0] raw, input logic f1, input logic f2,
                        input logic f3, input logic op, input logic r);
        @(negedge clk);
        raw_btn = raw; floor_one = f1; floor_two = f2; floor_three = f3;
        elevator_open = op; rst = r;
        model_edge(raw, f1, f2, f3, op, r);
    endtask

    task automatic idle(input logic [6:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_now(input string name, input logic [6:0] exp_req);
        @(posedge clk);
        #1;
        n_cmp++;
        if (req_a !== exp_req || any_a !== (|exp_req)) begin
            n_err++;
            $display("FAIL %s: req=%h any_req=%b, required req=%h any_req=%b",
                     name, req_a, any_a, exp_req, |exp_req);
        end
    endtask

    initial begin : monitor
        logic [15:0] e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({any_a, req_a} !== e[7:0]) begin
                    n_err++;
                    $display("FAIL sb_dc4 @%0t: req=%h any_req=%b, required req=%h any_req=%b",
                             $time, req_a, any_a, e[6:0], e[7]);
                end
                n_cmp++;
                if ({any_b, req_b} !== e[15:8]) begin
                    n_err++;
                    $display("FAIL sb_dc1 @%0t: req=%h any_req=%b, required req=%h any_req=%b",
                             $time, req_b, any_b, e[14:8], e[15]);
                end
            end
        end
    end

    initial begin : stimulus
        int unsigned hold [7];
        logic [6:0]  lvl;
        int unsigned fl;
        logic        f1, f2, f3, op, r;
        raw_btn = '0; floor_one = 1'b1; floor_two = 1'b0; floor_three = 1'b0;
        elevator_open = 1'b0; rst = 1'b1;

        for (int i = 0; i < 3; i++) step(7'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_now("reset_hold", 7'h00);
        idle(7'h7F, 1);
        expect_now("reset_after", 7'h00);
        idle(7'h00, 6);

        idle(7'h01, 5);
        expect_now("press_e4", 7'h00);
        idle(7'h01, 1);
        expect_now("press_e5", 7'h01);
        idle(7'h01, 8);
        expect_now("press_held", 7'h01);
        idle(7'h00, 6);
        expect_now("press_release", 7'h01);
        step(7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_now("clear_f1", 7'h00);

        idle(7'h20, 3);
        idle(7'h00, 6);
        expect_now("glitch_reject", 7'h00);
        idle(7'h20, 4);
        idle(7'h00, 2);
        expect_now("min_pulse", 7'h20);
        idle(7'h00, 4);

        idle(7'h36, 6);
        idle(7'h00, 6);
        expect_now("pending_36", 7'h36);
        step(7'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_now("service_f2", 7'h10);

        idle(7'h41, 5);
        step(7'h41, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_now("collision", 7'h11);
        idle(7'h41, 6);
        expect_now("collision_held", 7'h11);
        idle(7'h00, 6);

        idle(7'h08, 6);
        expect_now("f3_latch", 7'h19);
        step(7'h08, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(7'h08, 6);
        expect_now("held_through_svc", 7'h11);
        idle(7'h00, 6);
        idle(7'h08, 6);
        expect_now("relatch", 7'h19);
        idle(7'h00, 6);

        idle(7'h02, 3);
        step(7'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(7'h02, 5);
        expect_now("reset_mid_e4", 7'h00);
        idle(7'h02, 1);
        expect_now("reset_mid_e5", 7'h02);
        idle(7'h00, 6);

        for (int b = 0; b < 7; b++) hold[b] = 0;
        lvl = '0;
        fl  = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 7; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = $urandom_range(0, 1) == 1;
                    hold[b] = $urandom_range(1, 8);
                end
                hold[b]--;
            end
            if ($urandom_range(0, 7) == 0) fl = $urandom_range(0, 2);
            f1 = (fl == 0); f2 = (fl == 1); f3 = (fl == 2);
            if ($urandom_range(0, 15) == 0) begin
                f1 = $urandom_range(0, 1) == 1;
                f2 = $urandom_range(0, 1) == 1;
                f3 = $urandom_range(0, 1) == 1;
            end
            op = $urandom_range(0, 5) == 0;
            r  = $urandom_range(0, 299) == 0;
            step(lvl, f1, f2, f3, op, r);
        end
        idle(7'h00, 2);
        @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
